// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the async SRAM bank controller: FSM encoding and default wait timing.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WSETUP,
    S_WPULSE,
    S_WHOLD,
    S_RSP
  } state_t;

  localparam int RD_WAIT_DEF = 1;
  localparam int WR_WAIT_DEF = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Single-outstanding valid/ready word request to async SRAM pin sequencer.
// All pins are registered; the data bus is driven only from the data-OE register.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  inout  wire  [DATA_W-1:0]     ram_data,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_be_n,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(max2(RD_WAIT, WR_WAIT) + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ce_n_q, ce_n_nxt;
  logic                oe_n_q, oe_n_nxt;
  logic                we_n_q, we_n_nxt;
  logic                doe_q, doe_nxt;
  logic [BE_W-1:0]     be_n_q, be_n_nxt;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   wdata_q, wdata_nxt;
  logic [DATA_W-1:0]   rdata_q, rdata_nxt;
  logic                rsp_valid_q, rsp_valid_nxt;

  assign req_ready = (state == S_IDLE) & resetn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram_data  = doe_q ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      doe_q       <= 1'b0;
      be_n_q      <= '1;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ce_n_q      <= ce_n_nxt;
      oe_n_q      <= oe_n_nxt;
      we_n_q      <= we_n_nxt;
      doe_q       <= doe_nxt;
      be_n_q      <= be_n_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      rdata_q     <= rdata_nxt;
      rsp_valid_q <= rsp_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    ce_n_nxt      = ce_n_q;
    oe_n_nxt      = oe_n_q;
    we_n_nxt      = we_n_q;
    doe_nxt       = doe_q;
    be_n_nxt      = be_n_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    rdata_nxt     = rdata_q;
    rsp_valid_nxt = rsp_valid_q;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          addr_nxt  = req_addr;
          wdata_nxt = req_wdata;
          ce_n_nxt  = 1'b0;
          if (req_we) begin
            state_nxt = S_WSETUP;
            oe_n_nxt  = 1'b1;
            we_n_nxt  = 1'b1;
            be_n_nxt  = ~req_be;
            doe_nxt   = 1'b1;
          end else begin
            state_nxt = S_RD;
            oe_n_nxt  = 1'b0;
            be_n_nxt  = '0;
            cnt_nxt   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        if (cnt == '0) begin
          rdata_nxt     = ram_data;
          ce_n_nxt      = 1'b1;
          oe_n_nxt      = 1'b1;
          be_n_nxt      = '1;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RSP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WSETUP: begin
        we_n_nxt  = 1'b0;
        cnt_nxt   = WR_LOAD;
        state_nxt = S_WPULSE;
      end
      S_WPULSE: begin
        if (cnt == '0) begin
          we_n_nxt  = 1'b1;
          state_nxt = S_WHOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      S_WHOLD: begin
        // addr/data were held through this cycle so the we_n rising edge sees stable inputs
        ce_n_nxt      = 1'b1;
        doe_nxt       = 1'b0;
        be_n_nxt      = '1;
        rdata_nxt     = '0;
        rsp_valid_nxt = 1'b1;
        state_nxt     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAM, pin-protocol monitor and response scoreboard.
module tb_sram_ctrl;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int RD_WAIT = 1;
  localparam int WR_WAIT = 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [BW-1:0] req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  wire  [DW-1:0] ram_data;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be_n;
  logic          ram_ce_n, ram_oe_n, ram_we_n;

  always #10 clk = ~clk;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_data(ram_data), .ram_addr(ram_addr), .ram_be_n(ram_be_n),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // power-up content of the SRAM, known to both model and shadow
  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[11:0], a} ^ 32'h5A5A_C3C3;
  endfunction

  // ---------------- async SRAM model ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] model_q;
  logic          mem_upd = 1'b0;

  always @(ram_addr or mem_upd)
    model_q = mem.exists(ram_addr) ? mem[ram_addr] : init_word(ram_addr);

  assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? model_q : {DW{1'bz}};

  always @(posedge clk) begin
    logic [DW-1:0] w;
    if (!ram_ce_n && !ram_we_n) begin
      w = mem.exists(ram_addr) ? mem[ram_addr] : init_word(ram_addr);
      for (int b = 0; b < BW; b++)
        if (!ram_be_n[b]) w[8*b +: 8] = ram_data[8*b +: 8];
      mem[ram_addr] = w;
      mem_upd = ~mem_upd;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          we;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  int            cyc = 0;
  bit            first_seen = 0;
  logic [DW-1:0] last_rdata = '0;
  bit            hold_low = 0;
  bit            rnd_rdy = 0;

  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [BW-1:0] cur_be = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk)
    rsp_ready = hold_low ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);

  function automatic logic [DW-1:0] rd_shadow(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : init_word(a);
  endfunction

  // response channel monitor
  always @(negedge clk) begin
    #2;
    if (resetn && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_rsp", rsp_valid, 0);
      end else begin
        if (!first_seen) begin
          chk("latency", cyc - sbq[0].acc + 1, sbq[0].we ? WR_WAIT + 3 : RD_WAIT + 1);
          first_seen = 1;
        end
        chk("rsp_rdata", rsp_rdata, sbq[0].data);
        chk("req_ready_busy", req_ready, 0);
        if (rsp_ready) begin
          last_rdata = rsp_rdata;
          void'(sbq.pop_front());
          first_seen = 0;
        end
      end
    end
  end

  // pin protocol monitor
  logic          prev_ce_n = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      chk("oe_we_overlap", !ram_oe_n && !ram_we_n, 0);
      if (!ram_we_n) begin
        chk("wr_addr", ram_addr, cur_addr);
        chk("wr_be_n", ram_be_n, {60'b0, ~cur_be});
        chk("wr_data", ram_data, cur_wdata);
      end
      if (!ram_oe_n) begin
        chk("rd_addr", ram_addr, cur_addr);
        chk("rd_be_n", ram_be_n, 0);
      end
      if (!ram_ce_n && !prev_ce_n) chk("addr_stable", ram_addr, prev_addr);
    end
    prev_ce_n = ram_ce_n;
    prev_addr = ram_addr;
  end

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input bit track);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    #2;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk); #2; n++;
    end
    chk("accept_wait", 64'(n < 200), 1);
    if (n < 200) begin
      cur_we = we; cur_addr = a; cur_wdata = d; cur_be = be;
      if (track) begin
        e.we  = we;
        e.acc = cyc + 1;
        if (we) begin
          logic [DW-1:0] w;
          w = rd_shadow(a);
          for (int b = 0; b < BW; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
          shadow[a] = w;
          e.data = '0;
        end else begin
          e.data = rd_shadow(a);
        end
        sbq.push_back(e);
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_wait", 64'(n < 500), 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n", ram_ce_n, 1);
    chk("rst_oe_n", ram_oe_n, 1);
    chk("rst_we_n", ram_we_n, 1);
    chk("rst_be_n", ram_be_n, 4'hF);
    chk("rst_addr", ram_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk) resetn = 1'b1;

    // full word write then readback
    do_req(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF, 1);
    do_req(1'b0, 20'h00010, '0, 4'h0, 1);
    wait_idle();
    chk("t1_readback", last_rdata, 32'hDEADBEEF);

    // byte-lane write
    do_req(1'b1, 20'h00020, 32'h11223344, 4'hF, 1);
    do_req(1'b1, 20'h00020, 32'h0000AB00, 4'b0010, 1);
    do_req(1'b0, 20'h00020, '0, 4'h0, 1);
    wait_idle();
    chk("t2_byte_merge", last_rdata, 32'h1122AB44);

    // address extremes
    do_req(1'b1, 20'hFFFFF, 32'hA5A55A5A, 4'hF, 1);
    do_req(1'b1, 20'h00000, 32'h0F0F1234, 4'hF, 1);
    do_req(1'b0, 20'hFFFFF, '0, 4'h0, 1);
    wait_idle();
    chk("t3_top_addr", last_rdata, 32'hA5A55A5A);
    do_req(1'b0, 20'h00000, '0, 4'h0, 1);
    wait_idle();
    chk("t3_zero_addr", last_rdata, 32'h0F0F1234);

    // zero byte-enable write leaves the word unchanged but is acked
    do_req(1'b1, 20'h00010, 32'h0BADF00D, 4'h0, 1);
    do_req(1'b0, 20'h00010, '0, 4'h0, 1);
    wait_idle();
    chk("t_be0_unchanged", last_rdata, 32'hDEADBEEF);

    // response back-pressure
    hold_low = 1;
    do_req(1'b0, 20'h00020, '0, 4'h0, 1);
    repeat (10) @(negedge clk);
    #3;
    chk("t4_held_valid", rsp_valid, 1);
    chk("t4_held_ready", req_ready, 0);
    hold_low = 0;
    wait_idle();
    chk("t4_released", last_rdata, 32'h1122AB44);

    // reset during write pulse: dropped, no response
    do_req(1'b1, 20'h00030, 32'hCAFEF00D, 4'hF, 0);
    n = 0;
    while (ram_we_n && n < 20) begin
      @(negedge clk); n++;
    end
    chk("t5_pulse_seen", ram_we_n, 0);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_we_n", ram_we_n, 1);
    chk("t5_ce_n", ram_ce_n, 1);
    chk("t5_oe_n", ram_oe_n, 1);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 0);
    @(negedge clk) resetn = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    chk("t5_no_rsp", rsp_valid, 0);
    chk("t5_idle_ready", req_ready, 1);
    do_req(1'b1, 20'h00030, 32'h01234567, 4'hF, 1);
    do_req(1'b0, 20'h00030, '0, 4'h0, 1);
    wait_idle();
    chk("t5_recover", last_rdata, 32'h01234567);

    // random alternating traffic with random response back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 100; i++) begin
      logic [AW-1:0] a;
      a = 20'h00100 + 20'($urandom_range(0, 15));
      do_req(1'(i % 2 == 0), a, $urandom, 4'($urandom_range(0, 15)), 1);
    end
    wait_idle();
    rnd_rdy = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
